// File: rtl/elbeth_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and the memory.
interface elbeth_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;

  // Fetch unit side: drives the request, receives grant and response.
  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err
  );

  // Memory side.
  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err
  );
endinterface

// File: rtl/elbeth_fetch_unit.sv
// Instruction fetch stage: runs the PC, issues in-order memory requests under a
// credit limit, buffers returned words with their PCs and presents decoder field
// slices. Redirects flush the buffer and squash responses still in flight.
module elbeth_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  elbeth_fetch_unit_if.master         imem,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  input  logic                        id_stall,
  output logic                        if_valid,
  output logic [31:0]                 if_pc,
  output logic [6:0]                  opcode,
  output logic [4:0]                  inst_0,
  output logic [2:0]                  inst_1,
  output logic [4:0]                  inst_2,
  output logic [4:0]                  inst_3,
  output logic [6:0]                  inst_4,
  output logic                        if_fetch_err,
  output logic                        if_misaligned
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [6:0] NOP_OPCODE = 7'b0010011;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic        err;
    logic        mis;
  } entry_t;

  // Control state
  logic [31:0] pc_q, pc_d;              // next address to issue
  logic        started_q;               // first request only the cycle after reset release
  logic        held_q, held_d;          // a request is asserted but not yet granted
  logic [31:0] held_addr_q, held_addr_d;
  logic        halted_q, halted_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] tag_rd_q, tag_wr_q;

  // Storage
  entry_t      fifo_q [FIFO_DEPTH];
  logic [31:0] tag_q  [FIFO_DEPTH];     // PC of each granted request, in grant order

  logic        credit_ok, req, gnt_fire, rsp_fire, rsp_push, redir_mis, pop;
  logic [31:0] req_addr;
  entry_t      head;

  assign credit_ok = ({1'b0, count_q} + {1'b0, outstanding_q}) < (CW+1)'(FIFO_DEPTH);
  // A held request stays on the bus even when halted or after a redirect.
  assign req       = held_q || (started_q && !halted_q && credit_ok);
  assign req_addr  = held_q ? held_addr_q : pc_q;
  assign gnt_fire  = req && imem.imem_gnt;
  // A response with nothing outstanding is stray and ignored entirely.
  assign rsp_fire  = imem.imem_rvalid && (outstanding_q != '0);
  assign rsp_push  = rsp_fire && !redirect_valid && (drop_q == '0);
  assign redir_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign pop       = if_valid && !id_stall && !redirect_valid;

  assign imem.imem_req  = req;
  assign imem.imem_addr = req_addr;

  // Next-state: request hold, PC, credit counters, squash count and buffer pointers.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    pc_d          = pc_q;
    held_d        = req && !imem.imem_gnt;
    held_addr_d   = req_addr;
    halted_d      = halted_q;
    outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(rsp_fire);
    drop_d        = drop_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    // The PC advances when a fresh request first appears; a held one already consumed it.
    if (req && !held_q) pc_d = pc_q + 32'd4;

    if (redirect_valid) begin
      // Everything granted or still to be granted is stale; a response this cycle is discarded.
      drop_d   = outstanding_q + CW'(req) - CW'(rsp_fire);
      rd_ptr_d = '0;
      wr_ptr_d = redir_mis ? AW'(1) : '0;
      count_d  = redir_mis ? CW'(1) : '0;
      halted_d = redir_mis;
      if (!redir_mis) pc_d = redirect_pc;
    end else begin
      if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (rsp_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (imem.imem_err) halted_d = 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(rsp_push) - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      started_q     <= 1'b0;
      held_q        <= 1'b0;
      held_addr_q   <= '0;
      halted_q      <= 1'b0;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pc_q          <= pc_d;
      started_q     <= 1'b1;
      held_q        <= held_d;
      held_addr_q   <= held_addr_d;
      halted_q      <= halted_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_q      <= tag_rd_q + AW'(rsp_fire);
      tag_wr_q      <= tag_wr_q + AW'(gnt_fire);
    end
  end

  // Tag and instruction buffer storage writes.
  // NOTE: storage is not reset; counts and pointers decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (gnt_fire) tag_q[tag_wr_q] <= req_addr;
    if (redir_mis) begin
      fifo_q[0].word <= '0;
      fifo_q[0].pc   <= redirect_pc;
      fifo_q[0].err  <= 1'b0;
      fifo_q[0].mis  <= 1'b1;
    end else if (rsp_push) begin
      fifo_q[wr_ptr_q].word <= imem.imem_rdata;
      fifo_q[wr_ptr_q].pc   <= tag_q[tag_rd_q];
      fifo_q[wr_ptr_q].err  <= imem.imem_err;
      fifo_q[wr_ptr_q].mis  <= 1'b0;
    end
  end

  assign head     = fifo_q[rd_ptr_q];
  assign if_valid = (count_q != '0);

  // Head presentation: NOP fields when empty or when the head carries a fault.
  always_comb begin
    if_pc         = '0;
    opcode        = NOP_OPCODE;
    inst_0        = '0;
    inst_1        = '0;
    inst_2        = '0;
    inst_3        = '0;
    inst_4        = '0;
    if_fetch_err  = 1'b0;
    if_misaligned = 1'b0;
    if (if_valid) begin
      if_pc         = head.pc;
      if_fetch_err  = head.err;
      if_misaligned = head.mis;
      if (!head.err && !head.mis) begin
        opcode = head.word[6:0];
        inst_0 = head.word[11:7];
        inst_1 = head.word[14:12];
        inst_2 = head.word[19:15];
        inst_3 = head.word[24:20];
        inst_4 = head.word[31:25];
      end
    end
  end

endmodule
